// File: rtl/pea_cfg_loader.sv
// Configuration loader for the M x N processing element array.
// Streams N_BITS-wide words in over valid/ready, unpacks each word into two
// per-PE configuration slots, checks every field for legal encodings and
// reports completion with a one-cycle done pulse.
module pea_cfg_loader #(
  parameter int N_BITS        = 32,
  parameter int N_CFG_BITS_PE = 16,
  parameter int M             = 4,
  parameter int N             = 4,
  localparam int N_PE         = M * N,
  localparam int N_WORDS      = N_PE * N_CFG_BITS_PE / N_BITS,
  localparam int IDX_W        = (N_PE > 1) ? $clog2(N_PE) : 1,
  localparam int CNT_W        = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic [N_BITS-1:0]             cfg_data_i,
  input  logic                          cfg_valid_i,
  output logic                          cfg_ready_o,
  output logic [N_PE*N_CFG_BITS_PE-1:0] pe_cfg_o,
  output logic                          pe_cfg_valid_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          illegal_o,
  output logic [IDX_W-1:0]              err_idx_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  word_cnt_reg;
  logic              pe_cfg_valid_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              illegal_reg;
  logic [IDX_W-1:0]  err_idx_reg;

  logic              handshake;
  logic              wr_en;
  logic [1:0]        half_bad;
  logic [IDX_W-1:0]  base_idx;
  logic [IDX_W-1:0]  first_bad_idx;

  // A PE word is legal when the opcode is ADD..SGNMUL, neither input select
  // is 7, and the reserved upper bits are all zero.
  function automatic logic pe_cfg_legal(input logic [N_CFG_BITS_PE-1:0] c);
    return (c[3:0] <= 4'hC) && (c[6:4] != 3'd7) && (c[9:7] != 3'd7) &&
           (c[N_CFG_BITS_PE-1:10] == '0);
  endfunction

  assign cfg_ready_o = (state_reg == LOAD);
  assign handshake   = cfg_valid_i & cfg_ready_o;
  // Abort wins over a same-cycle handshake: the word is dropped.
  assign wr_en       = handshake & ~abort_i;

  // Legality of the lower (even PE) and upper (odd PE) halves of the word.
  for (genvar gi = 0; gi < 2; gi++) begin : g_half_chk
    assign half_bad[gi] =
      ~pe_cfg_legal(cfg_data_i[gi*N_CFG_BITS_PE +: N_CFG_BITS_PE]);
  end

  // The lower half has the smaller PE index, so it is reported first.
  assign base_idx      = IDX_W'(word_cnt_reg) << 1;
  assign first_bad_idx = half_bad[0] ? base_idx : (base_idx | IDX_W'(1));

  // Control FSM: sequences the load and produces all registered status.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg        <= IDLE;
      word_cnt_reg     <= '0;
      pe_cfg_valid_reg <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      illegal_reg      <= 1'b0;
      err_idx_reg      <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            state_reg        <= LOAD;
            word_cnt_reg     <= '0;
            pe_cfg_valid_reg <= 1'b0;
            illegal_reg      <= 1'b0;
            err_idx_reg      <= '0;
            busy_reg         <= 1'b1;
          end
        end
        LOAD: begin
          if (abort_i) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (handshake) begin
            word_cnt_reg <= word_cnt_reg + CNT_W'(1);
            if (!illegal_reg && (|half_bad)) begin
              illegal_reg <= 1'b1;
              err_idx_reg <= first_bad_idx;
            end
            if (word_cnt_reg == CNT_W'(N_WORDS - 1)) begin
              state_reg        <= DONE;
              done_reg         <= 1'b1;
              pe_cfg_valid_reg <= 1'b1;
              busy_reg         <= 1'b0;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // One register per bus word; each holds the two PE slots that word feeds.
  for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_word
    logic [N_BITS-1:0] word_reg;

    // Capture the accepted word into this slot pair when the counter points here.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        word_reg <= '0;
      end else if (wr_en && (word_cnt_reg == CNT_W'(gi))) begin
        word_reg <= cfg_data_i;
      end
    end

    assign pe_cfg_o[gi*N_BITS +: N_BITS] = word_reg;
  end

  assign pe_cfg_valid_o = pe_cfg_valid_reg;
  assign busy_o         = busy_reg;
  assign done_o         = done_reg;
  assign illegal_o      = illegal_reg;
  assign err_idx_o      = err_idx_reg;

endmodule

// File: tb/tb_pea_cfg_loader.sv
// Bench for pea_cfg_loader: table of full-load scenarios plus hand-written
// abort, async reset and ignored-input sequences. Slot writes are checked
// through a scoreboard queue the cycle after each accepted word.
module tb_pea_cfg_loader;

  localparam int N_BITS  = 32;
  localparam int N_PE    = 16;
  localparam int N_WORDS = 8;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 start_i;
  logic                 abort_i;
  logic [N_BITS-1:0]    cfg_data_i;
  logic                 cfg_valid_i;
  logic                 cfg_ready_o;
  logic [N_PE*16-1:0]   pe_cfg_o;
  logic                 pe_cfg_valid_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 illegal_o;
  logic [3:0]           err_idx_o;

  always #5 clk_i = ~clk_i;

  pea_cfg_loader dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .cfg_data_i     (cfg_data_i),
    .cfg_valid_i    (cfg_valid_i),
    .cfg_ready_o    (cfg_ready_o),
    .pe_cfg_o       (pe_cfg_o),
    .pe_cfg_valid_o (pe_cfg_valid_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .illegal_o      (illegal_o),
    .err_idx_o      (err_idx_o)
  );

  typedef logic [N_WORDS-1:0][N_BITS-1:0] load_t;

  typedef struct {
    load_t      words;
    bit         stall;
    bit         restart;
    bit         exp_illegal;
    logic [3:0] exp_err;
  } vec_t;

  typedef struct packed {
    logic [3:0]  slot;
    logic [15:0] value;
  } wr_t;

  wr_t              sb_q[$];
  logic [N_PE*16-1:0] model;
  int               n_checks = 0;
  int               n_fail   = 0;
  vec_t             vecs[5];

  task automatic check(input string name, input logic [N_PE*16-1:0] act,
                       input logic [N_PE*16-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Legal PE word: opcode varies per PE, selects are UP/LEFT (order by variant).
  function automatic logic [15:0] code(input int k, input int v);
    logic [3:0] fu;
    logic [2:0] sa;
    logic [2:0] sb;
    fu = 4'((k + v) % 13);
    sa = (v % 2 == 1) ? 3'd4 : 3'd3;
    sb = (v % 2 == 1) ? 3'd3 : 3'd4;
    return {6'b0, sb, sa, fu};
  endfunction

  function automatic load_t legal_load(input int v);
    load_t r;
    for (int w = 0; w < N_WORDS; w++) r[w] = {code(2*w+1, v), code(2*w, v)};
    return r;
  endfunction

  task automatic drain_sb();
    wr_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check($sformatf("slot%0d_write", e.slot), pe_cfg_o[e.slot*16 +: 16], e.value);
    end
  endtask

  // Drives start then the words; returns the cycle (start = 0) at which
  // done_o was seen, or -1, and how many stall cycles were inserted.
  task automatic run_load(input load_t words, input bit stall, input bit restart,
                          input int abort_word, output int done_cycle,
                          output int stalls, output bit aborted);
    int  cyc;
    int  w;
    bit  valid;
    done_cycle = -1;
    stalls     = 0;
    aborted    = 1'b0;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    cyc = 1;
    w = 0;
    check("busy_after_start", busy_o, 1);
    check("ready_in_load", cfg_ready_o, 1);
    while (w < N_WORDS) begin
      if (cyc > 40) begin
        n_checks++;
        n_fail++;
        $display("FAIL load_timeout: got %0d words expected %0d", w, N_WORDS);
        break;
      end
      valid       = !stall || (cyc % 2 == 1);
      cfg_valid_i = valid;
      cfg_data_i  = valid ? words[w] : 32'hDEAD_BEEF;
      abort_i     = valid && (w == abort_word);
      start_i     = restart && (w == 3);
      if (!valid) stalls++;
      if (valid && !abort_i) begin
        sb_q.push_back('{slot: 4'(2*w),   value: words[w][15:0]});
        sb_q.push_back('{slot: 4'(2*w+1), value: words[w][31:16]});
        model[w*N_BITS +: N_BITS] = words[w];
      end
      aborted = abort_i;
      @(negedge clk_i);
      cyc++;
      drain_sb();
      if (aborted) break;
      if (valid) w++;
    end
    cfg_valid_i = 1'b0;
    abort_i     = 1'b0;
    start_i     = 1'b0;
    if (!aborted && done_o) done_cycle = cyc - 1 + 0;
    if (!aborted && done_o) done_cycle = cyc;
  endtask

  initial begin
    int    dc;
    int    st;
    bit    ab;
    load_t lw;

    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    cfg_valid_i = 1'b0; cfg_data_i = '0;
    model = '0;

    vecs[0] = '{words: legal_load(0), stall: 0, restart: 0, exp_illegal: 0, exp_err: 4'd0};
    vecs[1] = '{words: legal_load(1), stall: 1, restart: 0, exp_illegal: 0, exp_err: 4'd0};
    lw = legal_load(2);
    lw[3][31:16] = 16'h000D;
    lw[5][6:4]   = 3'd7;
    vecs[2] = '{words: lw, stall: 0, restart: 0, exp_illegal: 1, exp_err: 4'd7};
    lw = legal_load(3);
    lw[2][15:10] = 6'h01;
    lw[2][19:16] = 4'hF;
    lw[6][9:7]   = 3'd7;
    vecs[3] = '{words: lw, stall: 1, restart: 0, exp_illegal: 1, exp_err: 4'd4};
    lw = legal_load(4);
    lw[0][25:23] = 3'd7;
    vecs[4] = '{words: lw, stall: 0, restart: 1, exp_illegal: 1, exp_err: 4'd1};

    @(negedge clk_i);
    check("rst_pe_cfg", pe_cfg_o, 0);
    check("rst_ready", cfg_ready_o, 0);
    check("rst_valid", pe_cfg_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_illegal", illegal_o, 0);
    check("rst_err_idx", err_idx_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Table-driven full loads.
    for (int i = 0; i < 5; i++) begin
      run_load(vecs[i].words, vecs[i].stall, vecs[i].restart, -1, dc, st, ab);
      $display("load %0d: stalls %0d done_cycle %0d illegal %0b err_idx %0d",
               i, st, dc, illegal_o, err_idx_o);
      check($sformatf("v%0d_done_cycle", i), 32'(dc), 32'(9 + st));
      check($sformatf("v%0d_cfg_valid", i), pe_cfg_valid_o, 1);
      check($sformatf("v%0d_busy_done", i), busy_o, 0);
      check($sformatf("v%0d_illegal", i), illegal_o, vecs[i].exp_illegal);
      check($sformatf("v%0d_err_idx", i), err_idx_o, vecs[i].exp_err);
      check($sformatf("v%0d_pe_cfg", i), pe_cfg_o, model);
      @(negedge clk_i);
      check($sformatf("v%0d_done_pulse", i), done_o, 0);
      check($sformatf("v%0d_valid_hold", i), pe_cfg_valid_o, 1);
      check($sformatf("v%0d_ready_idle", i), cfg_ready_o, 0);
    end

    // Abort together with the handshake of word 4.
    run_load(legal_load(7), 1'b0, 1'b0, 4, dc, st, ab);
    $display("abort load: aborted %0b busy %0b valid %0b", ab, busy_o, pe_cfg_valid_o);
    check("abort_seen", ab, 1);
    check("abort_busy", busy_o, 0);
    check("abort_ready", cfg_ready_o, 0);
    check("abort_valid", pe_cfg_valid_o, 0);
    check("abort_pe_cfg", pe_cfg_o, model);
    for (int i = 0; i < 3; i++) begin
      check("abort_no_done", done_o, 0);
      @(negedge clk_i);
    end

    // Async reset after word 2 of a load that already flagged an illegal field.
    lw = legal_load(5);
    lw[0][3:0] = 4'hE;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int w = 0; w < 3; w++) begin
      cfg_valid_i = 1'b1;
      cfg_data_i  = lw[w];
      @(negedge clk_i);
    end
    cfg_valid_i = 1'b0;
    check("pre_rst_illegal", illegal_o, 1);
    check("pre_rst_busy", busy_o, 1);
    #2 rst_i = 1'b1;
    #1;
    $display("async reset mid-load: busy %0b illegal %0b", busy_o, illegal_o);
    check("arst_pe_cfg", pe_cfg_o, 0);
    check("arst_ready", cfg_ready_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_illegal", illegal_o, 0);
    check("arst_valid", pe_cfg_valid_o, 0);
    model = '0;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Valid in IDLE must not be accepted.
    for (int i = 0; i < 3; i++) begin
      cfg_valid_i = 1'b1;
      cfg_data_i  = 32'hFFFF_FFFF;
      @(negedge clk_i);
      $display("idle valid %0d: ready %0b busy %0b", i, cfg_ready_o, busy_o);
      check("idle_ready", cfg_ready_o, 0);
      check("idle_no_write", pe_cfg_o, model);
    end
    cfg_valid_i = 1'b0;

    // Full load after reset.
    run_load(legal_load(9), 1'b0, 1'b0, -1, dc, st, ab);
    $display("post-reset load: done_cycle %0d illegal %0b", dc, illegal_o);
    check("post_rst_done_cycle", 32'(dc), 32'd9);
    check("post_rst_valid", pe_cfg_valid_o, 1);
    check("post_rst_illegal", illegal_o, 0);
    check("post_rst_pe_cfg", pe_cfg_o, model);
    @(negedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
